// File: rtl/snd_latch_mix.sv
// snd_latch_mix: sub-CPU clock enables, edge-triggered command latches and saturating sample mixer.
// Define SND_DC_BLOCK_EN to add a DC-blocking high-pass stage after the mixer.
module snd_latch_mix #(
    parameter int NCH     = 2,
    parameter int NLATCH  = 3,
    parameter int DIV_N   = 12,
    parameter int PHI2_LO = 4,
    parameter int SW      = 16
) (
    input  logic                I_SUBCLK,
    input  logic                I_SUB_RESETn,
    input  logic [7:0]          I_MCPU_DO,
    input  logic [NLATCH-1:0]   I_STROBE,
    input  logic [NLATCH-1:0]   I_RD_ACK,
    input  logic [NCH*SW-1:0]   I_SAMPLE,
    input  logic [NCH*2-1:0]    I_ATTEN,
    output logic                O_CPU_CE,
    output logic                O_PHI2,
    output logic                O_ODD_OR_EVEN,
    output logic [NLATCH*8-1:0] O_LATCH,
    output logic [NLATCH-1:0]   O_PENDING,
    output logic [NLATCH-1:0]   O_OVERRUN,
    output logic [SW-1:0]       O_SAMPLE,
    output logic                O_SAMPLE_VLD
);
    localparam int CW = $clog2(DIV_N + 1);
    localparam int EW = SW + $clog2(NCH) + 1;
    localparam logic signed [EW-1:0] SMAX = {{(EW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN = {{(EW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 odd_q, odd_d;
    logic                 ce;
    logic [7:0]           do_q;
    logic [NLATCH-1:0]    s_q, s_qq, cap;
    logic [NLATCH-1:0]    pend_q, pend_d, ovr_q, ovr_d;
    logic [NLATCH*8-1:0]  latch_q, latch_d;
    logic [NCH*EW-1:0]    st1_q, st1_d;
    logic                 vld1_q, vld1_d;
    logic signed [EW-1:0] sum;
    logic [SW-1:0]        sat;
    logic [SW-1:0]        mix_q, mix_d;
    logic                 vld2_q, vld2_d;

    assign ce            = (cnt_q == CW'(DIV_N));
    assign O_CPU_CE      = ce;
    assign O_PHI2        = (cnt_q > CW'(PHI2_LO)) && (cnt_q < CW'(DIV_N));
    assign O_ODD_OR_EVEN = odd_q;
    assign O_LATCH       = latch_q;
    assign O_PENDING     = pend_q;
    assign O_OVERRUN     = ovr_q;

    always_comb begin
        logic signed [EW-1:0] ext;
        // >= also recovers from any out-of-range count
        cnt_d   = (cnt_q >= CW'(DIV_N)) ? CW'(1) : cnt_q + CW'(1);
        odd_d   = odd_q ^ ce;
        cap     = s_q & ~s_qq;
        pend_d  = (pend_q & ~I_RD_ACK) | cap;
        ovr_d   = ovr_q | (cap & pend_q & ~I_RD_ACK);
        latch_d = latch_q;
        for (int k = 0; k < NLATCH; k++)
            if (cap[k]) latch_d[k*8 +: 8] = do_q;
        st1_d  = st1_q;
        vld1_d = ce;
        for (int k = 0; k < NCH; k++) begin
            ext = EW'($signed(I_SAMPLE[k*SW +: SW]));
            ext = ext >>> I_ATTEN[k*2 +: 2];
            if (ce) st1_d[k*EW +: EW] = ext;
        end
        sum = '0;
        for (int k = 0; k < NCH; k++)
            sum = sum + $signed(st1_q[k*EW +: EW]);
        sat    = (sum > SMAX) ? SMAX[SW-1:0] : (sum < SMIN) ? SMIN[SW-1:0] : sum[SW-1:0];
        mix_d  = vld1_q ? sat : mix_q;
        vld2_d = vld1_q;
    end

    always_ff @(posedge I_SUBCLK or negedge I_SUB_RESETn) begin
        if (!I_SUB_RESETn) begin
            cnt_q   <= CW'(1);
            odd_q   <= 1'b1;
            do_q    <= '0;
            s_q     <= '0;
            s_qq    <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            latch_q <= '0;
            st1_q   <= '0;
            vld1_q  <= 1'b0;
            mix_q   <= '0;
            vld2_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            odd_q   <= odd_d;
            do_q    <= I_MCPU_DO;
            s_q     <= I_STROBE;
            s_qq    <= s_q;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            latch_q <= latch_d;
            st1_q   <= st1_d;
            vld1_q  <= vld1_d;
            mix_q   <= mix_d;
            vld2_q  <= vld2_d;
        end
    end

`ifdef SND_DC_BLOCK_EN
    localparam logic signed [SW+1:0] DMAX = {3'b000, {(SW-1){1'b1}}};
    localparam logic signed [SW+1:0] DMIN = {3'b111, {(SW-1){1'b0}}};

    logic signed [SW+1:0] xe, xpe, ype, y;
    logic [SW-1:0]        ysat;
    logic [SW-1:0]        xp_q, xp_d, yp_q, yp_d, out_q, out_d;
    logic                 ovld_q, ovld_d;

    always_comb begin
        xe     = {{2{mix_q[SW-1]}}, mix_q};
        xpe    = {{2{xp_q[SW-1]}}, xp_q};
        ype    = {{2{yp_q[SW-1]}}, yp_q};
        y      = xe - xpe + ype - (ype >>> 8);
        ysat   = (y > DMAX) ? DMAX[SW-1:0] : (y < DMIN) ? DMIN[SW-1:0] : y[SW-1:0];
        xp_d   = vld2_q ? mix_q : xp_q;
        yp_d   = vld2_q ? ysat : yp_q;
        out_d  = vld2_q ? ysat : out_q;
        ovld_d = vld2_q;
    end

    always_ff @(posedge I_SUBCLK or negedge I_SUB_RESETn) begin
        if (!I_SUB_RESETn) begin
            xp_q   <= '0;
            yp_q   <= '0;
            out_q  <= '0;
            ovld_q <= 1'b0;
        end else begin
            xp_q   <= xp_d;
            yp_q   <= yp_d;
            out_q  <= out_d;
            ovld_q <= ovld_d;
        end
    end

    assign O_SAMPLE     = out_q;
    assign O_SAMPLE_VLD = ovld_q;
`else
    assign O_SAMPLE     = mix_q;
    assign O_SAMPLE_VLD = vld2_q;
`endif
endmodule

// File: tb/tb_snd_latch_mix.sv
// tb_snd_latch_mix: self-checking bench for snd_latch_mix in its default build.
module tb_snd_latch_mix;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  do_i;
    logic [2:0]  strobe, ack;
    logic [31:0] sample;
    logic [3:0]  atten;
    logic        cpu_ce, phi2, odd;
    logic [23:0] latch;
    logic [2:0]  pend, ovr;
    logic [15:0] out;
    logic        vld;

    int n_chk  = 0;
    int n_fail = 0;
    int since  = 99;
    logic [15:0] sb [$];

    snd_latch_mix dut (
        .I_SUBCLK(clk), .I_SUB_RESETn(rst_n), .I_MCPU_DO(do_i),
        .I_STROBE(strobe), .I_RD_ACK(ack), .I_SAMPLE(sample), .I_ATTEN(atten),
        .O_CPU_CE(cpu_ce), .O_PHI2(phi2), .O_ODD_OR_EVEN(odd),
        .O_LATCH(latch), .O_PENDING(pend), .O_OVERRUN(ovr),
        .O_SAMPLE(out), .O_SAMPLE_VLD(vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mix_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] sa, input logic [1:0] sb_);
        int xa = $signed(a);
        int xb = $signed(b);
        int s;
        s = (xa >>> sa) + (xb >>> sb_);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    // Output side of the scoreboard: pops on every valid while stimulus is outstanding
    always @(negedge clk) begin
        if (!rst_n) since = 99;
        else if (cpu_ce) since = 0;
        else since++;
        if (vld && sb.size() > 0) begin
            check("mix_latency", since, 2);
            check("mix_sample", out, sb.pop_front());
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"}, cpu_ce, 0);
        check({tag, "_phi2"}, phi2, 0);
        check({tag, "_odd"}, odd, 1);
        check({tag, "_latch"}, latch, 0);
        check({tag, "_pend"}, pend, 0);
        check({tag, "_ovr"}, ovr, 0);
        check({tag, "_sample"}, out, 0);
        check({tag, "_vld"}, vld, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] vec_a [7] = '{16'h7000, 16'h7000, 16'h8000, 16'h1234, 16'h8000, 16'h7FFF, 16'h7FFF};
        logic [15:0] vec_b [7] = '{16'h7000, 16'h7000, 16'hFFFF, 16'hF000, 16'h8000, 16'h0001, 16'h8000};
        logic [1:0]  vec_sa[7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
        logic [1:0]  vec_sb[7] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0};
        int cnt_m;
        int odd_m;
        int first_ce;
        rst_n = 1'b0; do_i = '0; strobe = '0; ack = '0; sample = '0; atten = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Clock generator against a reference counter
        cnt_m = 1; odd_m = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            odd_m ^= (cnt_m == 12) ? 1 : 0;
            cnt_m = (cnt_m == 12) ? 1 : cnt_m + 1;
            check("clk_ce", cpu_ce, cnt_m == 12);
            check("clk_phi2", phi2, cnt_m > 4 && cnt_m < 12);
            check("clk_odd", odd, odd_m);
        end

        // Latch 0: capture, then ack clears pending
        do_i = 8'h5A; strobe[0] = 1'b1;
        @(negedge clk);
        do_i = 8'h00;
        @(negedge clk);
        check("l0_data", latch[7:0], 8'h5A);
        check("l0_pend", pend[0], 1);
        strobe[0] = 1'b0; ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        check("l0_pend_ack", pend[0], 0);
        check("l0_ovr", ovr[0], 0);

        // Latch 1: second capture without ack overruns
        do_i = 8'h11; strobe[1] = 1'b1;
        @(negedge clk);
        strobe[1] = 1'b0;
        @(negedge clk);
        check("l1_first", latch[15:8], 8'h11);
        @(negedge clk);
        do_i = 8'h33; strobe[1] = 1'b1;
        @(negedge clk);
        strobe[1] = 1'b0;
        @(negedge clk);
        check("l1_data", latch[15:8], 8'h33);
        check("l1_pend", pend[1], 1);
        check("l1_ovr", ovr[1], 1);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        @(negedge clk);
        check("l1_pend_ack", pend[1], 0);
        check("l1_ovr_sticky", ovr[1], 1);

        // Latch 2: capture and ack on the same edge, then held strobe must not recapture
        do_i = 8'h77; strobe[2] = 1'b1;
        @(negedge clk);
        ack[2] = 1'b1;
        @(negedge clk);
        ack[2] = 1'b0;
        check("l2_data", latch[23:16], 8'h77);
        check("l2_pend", pend[2], 1);
        check("l2_ovr", ovr[2], 0);
        ack[2] = 1'b1;
        @(negedge clk);
        ack[2] = 1'b0;
        repeat (2) @(negedge clk);
        check("l2_held_pend", pend[2], 0);
        check("l2_held_ovr", ovr[2], 0);
        strobe[2] = 1'b0;
        check("l0_untouched", latch[7:0], 8'h5A);

        // Mixer: input side of the scoreboard pushes at each CE
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 30 && !cpu_ce; i++) @(negedge clk);
            check("mix_ce_seen", cpu_ce, 1);
            sample = {vec_b[v], vec_a[v]};
            atten  = {vec_sb[v], vec_sa[v]};
            sb.push_back(mix_model(vec_a[v], vec_b[v], vec_sa[v], vec_sb[v]));
            @(posedge clk);
            #1;
            atten  = 4'hF;
            sample = $urandom;
            for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
            check("mix_drain", sb.size(), 0);
            @(negedge clk);
            check("mix_vld_pulse", vld, 0);
        end

        // Asynchronous reset mid-strobe, away from any clock edge
        @(negedge clk);
        strobe[0] = 1'b1; do_i = 8'hAA;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        strobe[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        first_ce = 0;
        for (int i = 1; i <= 20 && first_ce == 0; i++) begin
            @(negedge clk);
            if (cpu_ce) first_ce = i;
        end
        check("post_reset_ce", first_ce, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/snd_latch_mix.md
Name: snd_latch_mix

Overview:
Parametrised sound-subsystem glue for multi-2A03 boards. It covers three jobs:
- Generates the shared sub-CPU clock enables (cpu_ce, phi2, odd/even).
- Captures main-CPU sound commands into NLATCH edge-triggered latches, with pending/overrun handshake flags.
- Mixes NCH signed APU samples, with per-channel runtime attenuation and saturation, into one output stream.

It sits between the main-CPU command decoder, the N sub-CPU cores and the audio output.

Parameters:
NCH, 2, number of APU sample channels mixed (1..8)
NLATCH, 3, number of command latches (1..8)
DIV_N, 12, sub-clock cycles per CPU cycle (>=6)
PHI2_LO, 4, phi2 high when PHI2_LO < cnt < DIV_N
SW, 16, sample width, signed two's complement

Ports:
I_SUBCLK  in  1  sub-system clock
I_SUB_RESETn  in  1  asynchronous active-low reset
I_MCPU_DO  in  8  main-CPU data bus
I_STROBE  in  NLATCH  per-latch capture strobe; rising edge captures
I_RD_ACK  in  NLATCH  per-latch read acknowledge from sub-CPU; level, clears pending
I_SAMPLE  in  NCH*SW  packed signed APU samples, channel k at [k*SW +: SW]
I_ATTEN  in  NCH*2  per-channel arithmetic right-shift, 0..3
O_CPU_CE  out  1  one-cycle CPU clock enable
O_PHI2  out  1  phi2 window
O_ODD_OR_EVEN  out  1  APU cycle parity, 1 = odd
O_LATCH  out  NLATCH*8  latched command bytes
O_PENDING  out  NLATCH  latch holds unread data
O_OVERRUN  out  NLATCH  sticky: capture while pending
O_SAMPLE  out  SW  mixed signed sample
O_SAMPLE_VLD  out  1  one-cycle strobe, O_SAMPLE updated

Behaviour:
- One clock, I_SUBCLK. I_SUB_RESETn is asynchronous and active-low: all registers reset immediately, with no clock required.
- Reset values: cnt=1, O_CPU_CE=0, O_PHI2=0, O_ODD_OR_EVEN=1, O_LATCH=0, O_PENDING=0, O_OVERRUN=0, O_SAMPLE=0, O_SAMPLE_VLD=0; all pipeline registers 0.

Clock generator:
- Counter cnt, width $clog2(DIV_N+1).
- cnt <= 1 if (cnt==DIV_N || cnt>DIV_N), else cnt+1. The cnt>DIV_N term is the illegal-state recovery.
- O_CPU_CE = (cnt==DIV_N), combinational from cnt.
- O_PHI2 = (cnt>PHI2_LO && cnt<DIV_N).
- O_ODD_OR_EVEN toggles on every edge where O_CPU_CE=1.
- Defaults: CE period 12, phi2 high 7 cycles (cnt 5..11).

Command latches (per index k):
- Every edge: do_q<=I_MCPU_DO, s_q[k]<=I_STROBE[k], s_qq[k]<=s_q[k].
- cap[k] = s_q[k] & ~s_qq[k]. On cap: O_LATCH[k]<=do_q, i.e. the data present during the first cycle the strobe is high.
- Latency: strobe high at edge e0 → O_LATCH and O_PENDING valid after edge e1.
- Pending:
  - cap & ~ack → 1
  - ~cap & ack → 0
  - cap & ack → 1 (new data wins, no overrun)
- Overrun: set on cap & pending & ~ack. Sticky until reset; the latch is still overwritten.
- A strobe held high captures once. It must return low for at least 1 cycle before re-arming.

Mixer (2-stage pipeline, advances only on O_CPU_CE):
- Stage 1, on the edge with O_CPU_CE=1: each channel is sign-extended to SW+$clog2(NCH)+1 bits, then arithmetic-shifted right by I_ATTEN[k]. A valid flag is set.
- Stage 2, the next edge:
  - sum all channels;
  - saturate to [-2^(SW-1), 2^(SW-1)-1];
  - register to O_SAMPLE;
  - O_SAMPLE_VLD=1 for exactly that one cycle.
- Total latency: 2 edges from the CE cycle.
- I_ATTEN is sampled with I_SAMPLE at stage 1; a change between CEs has no effect until the next CE.

Optional Feature:
Macro SND_DC_BLOCK_EN.
- Defined: a third stage after saturation, a DC-blocking high-pass:
  - y = x - x_prev + y_prev - (y_prev>>>8), computed at SW+2 bits;
  - result saturated to SW bits;
  - x_prev/y_prev update only on stage-2 valid;
  - O_SAMPLE/O_SAMPLE_VLD latency becomes 3 edges from CE.
- Not defined: no extra stage, latency 2, output = saturated sum.
- Reset clears x_prev/y_prev to 0.

Test Plan:
- Release reset, idle 40 cycles → O_CPU_CE pulses at cycles 11, 23, 35 after release (period 12). O_PHI2 is high for 7 cycles per period. O_ODD_OR_EVEN goes 1→0→1→0 on the CE edges.
- I_MCPU_DO=0x5A, I_STROBE[0] rises at e0 → O_LATCH[7:0]=0x5A and O_PENDING[0]=1 after e1. Then I_RD_ACK[0]=1 for 1 cycle → O_PENDING[0]=0 next edge, O_OVERRUN[0]=0.
- Strobe latch 1 with 0x11, then again with 0x33 and no ack → O_LATCH[15:8]=0x33, O_PENDING[1]=1, O_OVERRUN[1]=1, persisting after a later ack.
- Capture edge on latch 2 with I_RD_ACK[2]=1 in the same cycle → O_PENDING[2]=1, O_OVERRUN[2]=0.
- Mixer, feature off:
  - ch0=ch1=0x7000, atten 0 → O_SAMPLE=0x7FFF;
  - atten 1/1 → 0x7000;
  - ch0=0x8000, ch1=0xFFFF, atten 0 → 0x8000.
  - Each result has O_SAMPLE_VLD high exactly 2 edges after its CE.
- Assert I_SUB_RESETn low mid-strobe, with no clock edge → all outputs at their reset values immediately. After release, the first O_CPU_CE occurs 11 cycles later.
